// File: rtl/pc_sequencer_if.sv
// Fetch-side bundle between the PC sequencer, the PC register and instruction memory.
// The sequencer is the master; the PC / imem side is the slave.
interface pc_sequencer_if;
  logic        imem_req;
  logic        imem_ack;
  logic        En_PC;
  logic        stall_pc;
  logic        PC_Change;
  logic [31:0] PC_Addr;
  logic        flush_if;

  modport master (
    output imem_req,
    output En_PC,
    output stall_pc,
    output PC_Change,
    output PC_Addr,
    output flush_if,
    input  imem_ack
  );

  modport slave (
    input  imem_req,
    input  En_PC,
    input  stall_pc,
    input  PC_Change,
    input  PC_Addr,
    input  flush_if,
    output imem_ack
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: boot, fetch, redirect and halt/resume control of the PC.
// Define PC_SEQ_TRAP_EN to add trap handling (trap_req/trap_pc in, epc/cause out).
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned BOOT_CYCLES  = 4,
  parameter logic [31:0] MTVEC        = 32'h0000_0100
) (
  input  logic           CLK,
  input  logic           rst_n,
  pc_sequencer_if.master pc_bus,
  input  logic           stall_hz,
  input  logic           ex_redir,
  input  logic [31:0]    ex_target,
  input  logic           halt_req,
  input  logic           resume,
`ifdef PC_SEQ_TRAP_EN
  input  logic           trap_req,
  input  logic [31:0]    trap_pc,
  output logic [31:0]    epc,
  output logic [1:0]     cause,
`endif
  output logic           halted,
  output logic [1:0]     seq_state
);

  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_REDIR = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

  localparam int              CNT_W     = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(BOOT_CYCLES - 1);
  localparam logic [31:0]     RESET_TGT = align_word(RESET_VECTOR);
  localparam logic [31:0]     TRAP_TGT  = align_word(MTVEC);

  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic [31:0]      tgt_r;
  logic [31:0]      tgt_nxt_s;
  logic             pend_r;
  logic             pend_nxt_s;
  logic             trap_s;

  logic             imem_req_s;
  logic             en_pc_s;
  logic             stall_pc_s;
  logic             pc_change_s;
  logic [31:0]      pc_addr_s;
  logic             flush_if_s;
  logic             halted_s;

`ifdef PC_SEQ_TRAP_EN
  logic [31:0] epc_r;
  logic [31:0] epc_nxt_s;
  logic [1:0]  cause_r;
  logic [1:0]  cause_nxt_s;

  // Trap classification: an external request outranks a misaligned redirect target
  always_comb begin
    trap_s      = 1'b0;
    epc_nxt_s   = epc_r;
    cause_nxt_s = cause_r;
    if ((state_r == ST_RUN) || (state_r == ST_HALT)) begin
      if (trap_req) begin
        trap_s      = 1'b1;
        epc_nxt_s   = trap_pc;
        cause_nxt_s = 2'd1;
      end else if (ex_redir && (ex_target[1:0] != 2'b00)) begin
        trap_s      = 1'b1;
        epc_nxt_s   = ex_target;
        cause_nxt_s = 2'd2;
      end else begin
        trap_s      = 1'b0;
      end
    end else begin
      trap_s = 1'b0;
    end
  end

  // Trap record registers
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      epc_r   <= 32'h0000_0000;
      cause_r <= 2'd0;
    end else begin
      epc_r   <= epc_nxt_s;
      cause_r <= cause_nxt_s;
    end
  end

  assign epc   = epc_r;
  assign cause = cause_r;
`else
  assign trap_s = 1'b0;
`endif

  // Next-state selection and combinational drive of the PC controls
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    tgt_nxt_s   = tgt_r;
    pend_nxt_s  = pend_r;
    imem_req_s  = 1'b0;
    en_pc_s     = 1'b0;
    stall_pc_s  = 1'b0;
    pc_change_s = 1'b0;
    pc_addr_s   = 32'h0000_0000;
    flush_if_s  = 1'b0;
    halted_s    = 1'b0;
    case (state_r)
      ST_BOOT: begin
        if (cnt_r == BOOT_LAST) begin
          state_nxt_s = ST_REDIR;
          cnt_nxt_s   = {CNT_W{1'b0}};
          tgt_nxt_s   = RESET_TGT;
        end else begin
          cnt_nxt_s   = cnt_r + CNT_W'(1);
        end
      end
      ST_RUN: begin
        imem_req_s = 1'b1;
        if (trap_s) begin
          tgt_nxt_s   = TRAP_TGT;
          flush_if_s  = 1'b1;
          state_nxt_s = ST_REDIR;
        end else if (ex_redir) begin
          // Redirect wins over ack, stall and halt; the fetched word is wrong-path
          tgt_nxt_s   = align_word(ex_target);
          flush_if_s  = 1'b1;
          state_nxt_s = ST_REDIR;
        end else begin
          stall_pc_s = stall_hz;
          en_pc_s    = pc_bus.imem_ack;
          if (halt_req) begin
            state_nxt_s = ST_HALT;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
      end
      ST_REDIR: begin
        en_pc_s     = 1'b1;
        pc_change_s = 1'b1;
        pc_addr_s   = tgt_r;
        pend_nxt_s  = 1'b0;
        if (halt_req) begin
          state_nxt_s = ST_HALT;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_HALT: begin
        halted_s = 1'b1;
        if (trap_s) begin
          tgt_nxt_s  = TRAP_TGT;
          pend_nxt_s = 1'b1;
          flush_if_s = 1'b1;
        end else if (ex_redir) begin
          tgt_nxt_s  = align_word(ex_target);
          pend_nxt_s = 1'b1;
        end else begin
          pend_nxt_s = pend_r;
        end
        // A redirect arriving with resume is latched first, so pend_nxt_s decides
        if (resume) begin
          if (pend_nxt_s) begin
            state_nxt_s = ST_REDIR;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end else begin
          state_nxt_s = ST_HALT;
        end
      end
      default: begin
        state_nxt_s = ST_BOOT;
        cnt_nxt_s   = {CNT_W{1'b0}};
        tgt_nxt_s   = RESET_TGT;
        pend_nxt_s  = 1'b0;
      end
    endcase
  end

  // Sequencer state; reset returns to BOOT and discards any pending redirect
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_BOOT;
      cnt_r   <= {CNT_W{1'b0}};
      tgt_r   <= RESET_TGT;
      pend_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      tgt_r   <= tgt_nxt_s;
      pend_r  <= pend_nxt_s;
    end
  end

  assign pc_bus.imem_req  = imem_req_s;
  assign pc_bus.En_PC     = en_pc_s;
  assign pc_bus.stall_pc  = stall_pc_s;
  assign pc_bus.PC_Change = pc_change_s;
  assign pc_bus.PC_Addr   = pc_addr_s;
  assign pc_bus.flush_if  = flush_if_s;
  assign halted           = halted_s;
  assign seq_state        = state_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: boot, fetch/ack, redirect, halt/resume, async reset,
// and trap handling when PC_SEQ_TRAP_EN is defined.
module tb_pc_sequencer;
  logic        CLK;
  logic        rst_n;
  logic        stall_hz;
  logic        ex_redir;
  logic [31:0] ex_target;
  logic        halt_req;
  logic        resume;
  logic        halted;
  logic [1:0]  seq_state;
`ifdef PC_SEQ_TRAP_EN
  logic        trap_req;
  logic [31:0] trap_pc;
  logic [31:0] epc;
  logic [1:0]  cause;
  localparam logic [31:0] ADDR_123 = 32'h0000_0100;
`else
  localparam logic [31:0] ADDR_123 = 32'h0000_0120;
`endif

  int checks_n = 0;
  int errors_n = 0;

  pc_sequencer_if bus ();

  pc_sequencer #(
    .RESET_VECTOR(32'h0000_0040),
    .BOOT_CYCLES (4),
    .MTVEC       (32'h0000_0100)
  ) dut (
    .CLK      (CLK),
    .rst_n    (rst_n),
    .pc_bus   (bus),
    .stall_hz (stall_hz),
    .ex_redir (ex_redir),
    .ex_target(ex_target),
    .halt_req (halt_req),
    .resume   (resume),
`ifdef PC_SEQ_TRAP_EN
    .trap_req (trap_req),
    .trap_pc  (trap_pc),
    .epc      (epc),
    .cause    (cause),
`endif
    .halted   (halted),
    .seq_state(seq_state)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_n++;
    if (obs !== exp) begin
      errors_n++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_ctl(input string tag, input logic [1:0] st, input logic req,
                            input logic en, input logic stall, input logic chg,
                            input logic [31:0] addr, input logic flush);
    check_val({tag, ".state"}, 32'(seq_state), 32'(st));
    check_val({tag, ".halted"}, 32'(halted), (st == 2'd3) ? 32'd1 : 32'd0);
    check_val({tag, ".imem_req"}, 32'(bus.imem_req), 32'(req));
    check_val({tag, ".En_PC"}, 32'(bus.En_PC), 32'(en));
    check_val({tag, ".stall_pc"}, 32'(bus.stall_pc), 32'(stall));
    check_val({tag, ".PC_Change"}, 32'(bus.PC_Change), 32'(chg));
    check_val({tag, ".PC_Addr"}, bus.PC_Addr, addr);
    check_val({tag, ".flush_if"}, 32'(bus.flush_if), 32'(flush));
  endtask

  task automatic cyc;
    @(posedge CLK);
    #1;
  endtask

  task automatic boot_seq(input string tag);
    for (int i = 0; i < 4; i++) begin
      ex_redir  = (i < 3);
      ex_target = 32'h0000_0700;
      @(negedge CLK);
      expect_ctl($sformatf("%s_boot%0d", tag, i), 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      cyc();
    end
    ex_redir = 1'b0;
    @(negedge CLK);
    expect_ctl({tag, "_redir"}, 2'd2, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0040, 1'b0);
    cyc();
    @(negedge CLK);
    expect_ctl({tag, "_run"}, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; stall_hz = 1'b0; ex_redir = 1'b0; ex_target = 32'h0;
    halt_req = 1'b0; resume = 1'b0; bus.imem_ack = 1'b0;
`ifdef PC_SEQ_TRAP_EN
    trap_req = 1'b0; trap_pc = 32'h0;
`endif
    #2;
    expect_ctl("reset", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    repeat (2) @(posedge CLK);
    #1 rst_n = 1'b1;
    boot_seq("b1");
    cyc();

    // Acks every other cycle; En_PC follows ack
    for (int i = 0; i < 4; i++) begin
      bus.imem_ack = (i % 2 == 0);
      @(negedge CLK);
      expect_ctl($sformatf("ack%0d", i), 2'd1, 1'b1, (i % 2 == 0), 1'b0, 1'b0, 32'h0, 1'b0);
      cyc();
    end
    stall_hz = 1'b1; bus.imem_ack = 1'b1;
    @(negedge CLK);
    expect_ctl("stall_ack", 2'd1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    cyc();
    bus.imem_ack = 1'b0;
    @(negedge CLK);
    expect_ctl("stall_noack", 2'd1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    cyc();

    // Redirect with ack and stall in the same cycle
    ex_redir = 1'b1; ex_target = 32'h0000_0123; bus.imem_ack = 1'b1;
    @(negedge CLK);
    expect_ctl("redir", 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    cyc();
    stall_hz = 1'b0; ex_target = 32'h0000_0500;
    @(negedge CLK);
    expect_ctl("redir_load", 2'd2, 1'b0, 1'b1, 1'b0, 1'b1, ADDR_123, 1'b0);
    cyc();
    ex_redir = 1'b0; bus.imem_ack = 1'b0;
    @(negedge CLK);
    expect_ctl("redir_ign0", 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc();
    @(negedge CLK);
    expect_ctl("redir_ign1", 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc();

    // Halt, two redirects while halted (last wins), then resume
    halt_req = 1'b1; bus.imem_ack = 1'b1;
    @(negedge CLK);
    expect_ctl("halt_req", 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc();
    ex_redir = 1'b1; ex_target = 32'h0000_0300;
    @(negedge CLK);
    expect_ctl("halted0", 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc();
    ex_target = 32'h0000_0200;
    @(negedge CLK);
    expect_ctl("halted1", 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc();
    ex_redir = 1'b0; halt_req = 1'b0; resume = 1'b1; bus.imem_ack = 1'b0;
    @(negedge CLK);
    expect_ctl("resume", 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc();
    resume = 1'b0;
    @(negedge CLK);
    expect_ctl("resume_redir", 2'd2, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0200, 1'b0);
    cyc();
    @(negedge CLK);
    expect_ctl("resume_run", 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

    // Resume and redirect in the same cycle
    halt_req = 1'b1;
    cyc();
    halt_req = 1'b0; resume = 1'b1; ex_redir = 1'b1; ex_target = 32'h0000_02A4;
    @(negedge CLK);
    expect_ctl("res_redir", 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc();
    resume = 1'b0; ex_redir = 1'b0;
    @(negedge CLK);
    expect_ctl("res_redir_load", 2'd2, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_02A4, 1'b0);
    cyc();

    // Resume with nothing pending goes straight to RUN
    halt_req = 1'b1;
    cyc();
    halt_req = 1'b0; resume = 1'b1;
    cyc();
    resume = 1'b0;
    @(negedge CLK);
    expect_ctl("res_nopend", 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

    // halt_req seen during REDIR lands in HALT
    ex_redir = 1'b1; ex_target = 32'h0000_0080;
    cyc();
    ex_redir = 1'b0; halt_req = 1'b1;
    @(negedge CLK);
    expect_ctl("redir_halt", 2'd2, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0080, 1'b0);
    cyc();
    halt_req = 1'b0; resume = 1'b1;
    @(negedge CLK);
    expect_ctl("redir_halted", 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc();
    resume = 1'b0;
    @(negedge CLK);
    expect_ctl("redir_halt_run", 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

`ifdef PC_SEQ_TRAP_EN
    trap_req = 1'b1; trap_pc = 32'h0000_0088; ex_redir = 1'b1; ex_target = 32'h0000_0300;
    @(negedge CLK);
    expect_ctl("trap_ext", 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    cyc();
    trap_req = 1'b0; ex_redir = 1'b0;
    @(negedge CLK);
    expect_ctl("trap_ext_load", 2'd2, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0100, 1'b0);
    check_val("trap_ext.epc", epc, 32'h0000_0088);
    check_val("trap_ext.cause", 32'(cause), 32'd1);
    cyc();
    ex_redir = 1'b1; ex_target = 32'h0000_0012;
    @(negedge CLK);
    expect_ctl("trap_mis", 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    cyc();
    ex_redir = 1'b0;
    @(negedge CLK);
    expect_ctl("trap_mis_load", 2'd2, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0100, 1'b0);
    check_val("trap_mis.epc", epc, 32'h0000_0012);
    check_val("trap_mis.cause", 32'(cause), 32'd2);
    cyc();
`endif

    // Asynchronous reset in the middle of a REDIR cycle
    ex_redir = 1'b1; ex_target = 32'h0000_0700;
    cyc();
    ex_redir = 1'b0;
    @(negedge CLK);
    expect_ctl("pre_rst", 2'd2, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0700, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    expect_ctl("async_rst", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
`ifdef PC_SEQ_TRAP_EN
    check_val("async_rst.epc", epc, 32'h0);
    check_val("async_rst.cause", 32'(cause), 32'd0);
`endif
    repeat (2) @(posedge CLK);
    #1 rst_n = 1'b1;
    boot_seq("b2");

    $display("CHECKS %0d ERRORS %0d", checks_n, errors_n);
    $finish;
  end
endmodule
